accum_alu_seq: RTL
==================

Name: accum_alu_seq

Overview:
- Parametrised accumulator ALU; successor to the fixed 16-bit opcode-decoded breadboard ALU.
- Holds a WIDTH-bit accumulator and applies one opcode per accepted transaction against operand in_a.
- Adds a valid/ready handshake, registered outputs, error flags and an iterative multi-cycle divider/modulus engine.
- Sits between the stimulus/control front end and the result display/consumer.

Parameters:
- WIDTH, 16, operand and accumulator width in bits (must be >= 2); result bus is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  transaction request.
- in_ready  out  1  block can accept; transfer occurs on any clk edge with in_valid && in_ready.
- opcode  in  4  operation select; sampled on transfer.
- in_a  in  WIDTH  operand; sampled on transfer.
- out_valid  out  1  one-cycle pulse: acc, c and error hold a newly completed result.
- acc  out  WIDTH  accumulator value (registered).
- c  out  2*WIDTH  registered full result of the last completed op.
- error  out  2  [0] overflow, [1] divide-by-zero; reflects the last completed op.

Behaviour:
- Reset (rst high at an edge):
  - acc=0, c=0, error=00, out_valid=0, in_ready=1, state=IDLE.
  - Reset overrides everything, including an in-flight division, which is aborted with no out_valid.
- States: IDLE, DIVIDE.
- IDLE:
  - in_ready=1.
  - Single-cycle op accepted at edge k: acc, c and error update at edge k; out_valid=1 for the following cycle.
  - Back-to-back transfers run at one op per cycle.
- Opcode map; opd=in_a; all results are mod 2^WIDTH unless stated:
  - 0 NOOP: acc held; c={0,acc}; error=00.
  - 1 RESET: acc=0; c=0; error=00.
  - 2 PRESET: acc=all ones; c={0,all ones}; error=00.
  - 3 reserved: behaves as NOOP.
  - 4 ADD: acc=acc+opd; error[0]=carry-out.
  - 5 SUB: acc=acc-opd; error[0]=borrow (acc<opd, unsigned).
  - 6 MUL: c=full 2*WIDTH unsigned product; acc=low WIDTH bits; error[0]=(high half != 0).
  - 7 DIV: acc=acc/opd, unsigned.
  - 8 MOD: acc=acc%opd, unsigned.
  - 9 AND, 10 OR, 11 XOR: acc=acc op opd.
  - 12 NOT: acc=~acc (opd ignored).
  - 13 NAND, 14 NOR, 15 XNOR: acc=~(acc op opd).
  - For all ops except MUL: c={WIDTH zeros, new acc}.
  - error[1]=0 for all ops except a DIV/MOD by zero.
  - error[0]=0 for all ops other than ADD/SUB/MUL.
- DIV/MOD with opd != 0:
  - Transfer at edge k loads dividend=acc, divisor=opd, count=0, state=DIVIDE; in_ready=0 from edge k.
  - Restoring shift-subtract, one quotient bit per edge, for WIDTH edges (k+1..k+WIDTH).
  - At edge k+WIDTH: acc=quotient (DIV) or remainder (MOD); c zero-extended; error=00; out_valid=1; state=IDLE; in_ready=1.
  - Latency WIDTH+1 edges from transfer to result visible; in_ready low for exactly WIDTH cycles.
  - in_valid, opcode and in_a are ignored while in DIVIDE; acc output holds the old value until completion.
- DIV/MOD with opd == 0:
  - Single-cycle; acc unchanged; c={0,acc}; error=10; out_valid pulses; stays IDLE.
- out_valid is never asserted in the cycle after reset or after an aborted division.

Test Plan:
- rst; PRESET; ADD in_a=1 -> acc=0x0000, c=0x00000000, error=01, out_valid 1 cycle per op.
- RESET; ADD 10; ADD 12 -> acc=22, error=00; SUB 23 -> acc=0xFFFF, error=01; back-to-back with in_valid held high, one out_valid per cycle.
- MUL, two cases:
  - acc=20, MUL 20 -> c=400, acc=400, error=00.
  - acc=0x9C41, MUL 0x9C41 -> c=0x5F5F4881, acc=0x4881, error=01.
- DIV, MOD and busy behaviour:
  - acc=20, DIV 5 -> in_ready low 16 cycles; out_valid 17 edges after transfer; acc=4, error=00.
  - An ADD presented while busy is ignored (acc stays 4, no extra out_valid).
  - acc=11, MOD 2 -> acc=1.
- acc=7, DIV 0 and MOD 0 -> out_valid next cycle, acc=7, error=10; following AND 0x000F -> acc=7, error=00.
- acc=0x9C42, DIV 0x9C41; assert rst at the 5th iteration edge -> next cycle acc=0, error=00, in_ready=1, and no out_valid for the rest of the original 16-cycle window.

Source files
------------

// File: rtl/accum_alu_seq_if.sv
// Transaction bus of accum_alu_seq: request side (in_valid/in_ready/opcode/in_a)
// and registered result side (out_valid/acc/c/error).
interface accum_alu_seq_if #(parameter int WIDTH = 16);
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           opcode;
  logic [WIDTH-1:0]     in_a;
  logic                 out_valid;
  logic [WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]   c;
  logic [1:0]           error;

  modport master (
    output in_valid, opcode, in_a,
    input  in_ready, out_valid, acc, c, error
  );

  modport slave (
    input  in_valid, opcode, in_a,
    output in_ready, out_valid, acc, c, error
  );
endinterface

// File: rtl/accum_alu_seq.sv
// Accumulator ALU: one opcode per accepted transaction against in_a, registered
// results with error flags, and a bit-serial restoring divider for DIV/MOD.
module accum_alu_seq #(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst,
  accum_alu_seq_if.slave bus
);
  // state  | meaning
  // IDLE   | accepting ops; single-cycle ops complete on the transfer edge
  // DIVIDE | restoring division, one quotient bit per edge; inputs ignored
  typedef enum logic {IDLE, DIVIDE} state_t;

  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_RESET  = 4'd1;
  localparam logic [3:0] OP_PRESET = 4'd2;
  localparam logic [3:0] OP_ADD    = 4'd4;
  localparam logic [3:0] OP_SUB    = 4'd5;
  localparam logic [3:0] OP_MUL    = 4'd6;
  localparam logic [3:0] OP_DIV    = 4'd7;
  localparam logic [3:0] OP_MOD    = 4'd8;
  localparam logic [3:0] OP_AND    = 4'd9;
  localparam logic [3:0] OP_OR     = 4'd10;
  localparam logic [3:0] OP_XOR    = 4'd11;
  localparam logic [3:0] OP_NOT    = 4'd12;
  localparam logic [3:0] OP_NAND   = 4'd13;
  localparam logic [3:0] OP_NOR    = 4'd14;
  localparam logic [3:0] OP_XNOR   = 4'd15;

  state_t               state, stateNext;
  logic [WIDTH-1:0]     accReg, accNext;
  logic [2*WIDTH-1:0]   cReg, cNext;
  logic [1:0]           errReg, errNext;
  logic                 outValidReg, outValidNext;
  logic [CW-1:0]        count, countNext;
  logic [WIDTH-1:0]     divisor, divisorNext;
  logic [WIDTH-1:0]     remReg, remNext;
  logic [WIDTH-1:0]     quoReg, quoNext;
  logic                 isMod, isModNext;

  logic [WIDTH:0]       sum, diff, trial;
  logic [2*WIDTH-1:0]   prod;
  logic                 take;
  logic [WIDTH-1:0]     remStep, quoStep, divResult, opResult;

  assign sum  = {1'b0, accReg} + {1'b0, bus.in_a};
  assign diff = {1'b0, accReg} - {1'b0, bus.in_a};
  assign prod = {{WIDTH{1'b0}}, accReg} * {{WIDTH{1'b0}}, bus.in_a};

  // A set remainder MSB means the shifted value already exceeds any divisor.
  assign trial     = {remReg, quoReg[WIDTH-1]} - {1'b0, divisor};
  assign take      = remReg[WIDTH-1] | ~trial[WIDTH];
  assign remStep   = take ? trial[WIDTH-1:0] : {remReg[WIDTH-2:0], quoReg[WIDTH-1]};
  assign quoStep   = {quoReg[WIDTH-2:0], take};
  assign divResult = isMod ? remStep : quoStep;

  always_comb begin
    opResult = accReg;
    case (bus.opcode)
      OP_RESET:  opResult = '0;
      OP_PRESET: opResult = '1;
      OP_ADD:    opResult = sum[WIDTH-1:0];
      OP_SUB:    opResult = diff[WIDTH-1:0];
      OP_MUL:    opResult = prod[WIDTH-1:0];
      OP_AND:    opResult = accReg & bus.in_a;
      OP_OR:     opResult = accReg | bus.in_a;
      OP_XOR:    opResult = accReg ^ bus.in_a;
      OP_NOT:    opResult = ~accReg;
      OP_NAND:   opResult = ~(accReg & bus.in_a);
      OP_NOR:    opResult = ~(accReg | bus.in_a);
      OP_XNOR:   opResult = ~(accReg ^ bus.in_a);
      default:   opResult = accReg;
    endcase
  end

  always_comb begin
    stateNext    = state;
    accNext      = accReg;
    cNext        = cReg;
    errNext      = errReg;
    outValidNext = 1'b0;
    countNext    = count;
    divisorNext  = divisor;
    remNext      = remReg;
    quoNext      = quoReg;
    isModNext    = isMod;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          outValidNext = 1'b1;
          accNext      = opResult;
          cNext        = {{WIDTH{1'b0}}, opResult};
          errNext      = 2'b00;
          case (bus.opcode)
            OP_ADD: errNext[0] = sum[WIDTH];
            OP_SUB: errNext[0] = diff[WIDTH];
            OP_MUL: begin
              cNext      = prod;
              errNext[0] = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV, OP_MOD: begin
              if (bus.in_a == '0) begin
                errNext = 2'b10;
              end else begin
                // Visible results keep their old values until the divider finishes.
                outValidNext = 1'b0;
                accNext      = accReg;
                cNext        = cReg;
                errNext      = errReg;
                stateNext    = DIVIDE;
                divisorNext  = bus.in_a;
                quoNext      = accReg;
                remNext      = '0;
                countNext    = '0;
                isModNext    = (bus.opcode == OP_MOD);
              end
            end
            default: ;
          endcase
        end
      end
      DIVIDE: begin
        remNext   = remStep;
        quoNext   = quoStep;
        countNext = count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          stateNext    = IDLE;
          outValidNext = 1'b1;
          accNext      = divResult;
          cNext        = {{WIDTH{1'b0}}, divResult};
          errNext      = 2'b00;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      accReg      <= '0;
      cReg        <= '0;
      errReg      <= 2'b00;
      outValidReg <= 1'b0;
      count       <= '0;
      divisor     <= '0;
      remReg      <= '0;
      quoReg      <= '0;
      isMod       <= 1'b0;
    end else begin
      state       <= stateNext;
      accReg      <= accNext;
      cReg        <= cNext;
      errReg      <= errNext;
      outValidReg <= outValidNext;
      count       <= countNext;
      divisor     <= divisorNext;
      remReg      <= remNext;
      quoReg      <= quoNext;
      isMod       <= isModNext;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = outValidReg;
  assign bus.acc       = accReg;
  assign bus.c         = cReg;
  assign bus.error     = errReg;
endmodule
